// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: shared opcodes and default sizing for the pipelined adder
package pipe_adder_pkg;
    typedef enum logic {ADD = 1'b0, SUB = 1'b1} op_e;
    localparam int DEF_WIDTH  = 32;
    localparam int DEF_STAGES = 2;
    localparam int DEF_TAG_W  = 5;
endpackage

// File: rtl/add_slice.sv
// add_slice: combinational slice-width adder with carry-in and carry-out
module add_slice #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: STAGES-deep carry-sliced adder/subtractor with valid/ready flow control
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES,
    parameter int TAG_W  = DEF_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             ovf,
    output logic             zero,
    output logic [TAG_W-1:0] tag_out
);
    localparam int SW = WIDTH / STAGES;
    localparam int L  = STAGES - 1;

    logic adv;

    if (STAGES < 1 || STAGES > 4 || WIDTH % STAGES != 0) begin : g_bad
        $error("pipe_adder: STAGES must be 1..4 and divide WIDTH");
    end

    // Stage k adds slice k; operands still to be added shrink and finished result bits grow per stage
    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int RW = WIDTH - k * SW;
        localparam int DW = (k + 1) * SW;
        logic [RW-1:0]    a_i, b_i;
        logic             c_i, v_i;
        logic [TAG_W-1:0] t_i;
        logic [SW-1:0]    s;
        logic             co;
        logic [DW-1:0]    r_n;
        logic             v_q, c_q;
        logic [DW-1:0]    r_q;
        logic [TAG_W-1:0] t_q;
        if (k == 0) begin : g_head
            assign a_i = a;
            assign b_i = (sub == SUB) ? ~b : b;
            assign c_i = (sub == SUB);
            assign v_i = in_valid;
            assign t_i = tag_in;
            assign r_n = s;
        end else begin : g_body
            assign a_i = g_st[k-1].g_op.a_q;
            assign b_i = g_st[k-1].g_op.b_q;
            assign c_i = g_st[k-1].c_q;
            assign v_i = g_st[k-1].v_q;
            assign t_i = g_st[k-1].t_q;
            assign r_n = {s, g_st[k-1].r_q};
        end
        add_slice #(.W(SW)) u_slice (
            .a    (a_i[SW-1:0]),
            .b    (b_i[SW-1:0]),
            .cin  (c_i),
            .sum  (s),
            .cout (co)
        );
        // stage register: moves with the whole pipe on adv, holds otherwise
        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                r_q <= '0;
                t_q <= '0;
            end else if (adv) begin
                v_q <= v_i;
                c_q <= co;
                r_q <= r_n;
                t_q <= t_i;
            end
        end
        if (k < L) begin : g_op
            logic [RW-SW-1:0] a_q, b_q;
            // operand skew: carry the not-yet-added upper slices to the next stage
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_i[RW-1:SW];
                    b_q <= b_i[RW-1:SW];
                end
            end
        end else begin : g_ovf
            logic o_q;
            // signed overflow judged on the top slice sign bits of A, effective B and the sum
            always_ff @(posedge clk) begin
                if (rst) o_q <= 1'b0;
                else if (adv) o_q <= (a_i[SW-1] == b_i[SW-1]) && (s[SW-1] != a_i[SW-1]);
            end
        end
    end

    assign adv       = ~out_valid | out_ready;
    assign in_ready  = adv;
    assign out_valid = g_st[L].v_q;
    assign result    = g_st[L].r_q;
    assign carry     = g_st[L].c_q;
    assign ovf       = g_st[L].g_ovf.o_q;
    assign tag_out   = g_st[L].t_q;
    assign zero      = out_valid & ~|result;
endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: table vectors, directed corner sequences and scoreboarded random traffic on 1/2/4-stage builds
module tb_pipe_adder;
    typedef struct packed {
        logic [31:0] r;
        logic        c;
        logic        o;
        logic        z;
        logic [4:0]  t;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [4:0]  t;
        exp_t        e;
    } vec_t;

    localparam int ST [3] = '{2, 1, 4};

    logic        clk = 1'b0;
    logic        rst, in_valid, sub, out_ready;
    logic [31:0] a, b;
    logic [4:0]  tag_in;
    logic        ir [3], ov [3], cy [3], of [3], zr [3];
    logic [31:0] res [3];
    logic [4:0]  tg [3];
    exp_t        sbq [3][$];
    logic        stall_prev [3];
    int          n_out [3];
    int          n_chk = 0;
    int          n_fail = 0;
    vec_t        tbl [9];

    always #5 clk = ~clk;

    pipe_adder #(.WIDTH(32), .STAGES(2), .TAG_W(5)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .a(a), .b(b), .sub(sub),
        .tag_in(tag_in), .out_valid(ov[0]), .out_ready(out_ready), .result(res[0]), .carry(cy[0]),
        .ovf(of[0]), .zero(zr[0]), .tag_out(tg[0])
    );
    pipe_adder #(.WIDTH(32), .STAGES(1), .TAG_W(5)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .a(a), .b(b), .sub(sub),
        .tag_in(tag_in), .out_valid(ov[1]), .out_ready(out_ready), .result(res[1]), .carry(cy[1]),
        .ovf(of[1]), .zero(zr[1]), .tag_out(tg[1])
    );
    pipe_adder #(.WIDTH(32), .STAGES(4), .TAG_W(5)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .a(a), .b(b), .sub(sub),
        .tag_in(tag_in), .out_valid(ov[2]), .out_ready(out_ready), .result(res[2]), .carry(cy[2]),
        .ovf(of[2]), .zero(zr[2]), .tag_out(tg[2])
    );

    function automatic exp_t model(logic [31:0] x, logic [31:0] y, logic s, logic [4:0] t);
        logic [31:0] ye;
        logic [32:0] sum;
        exp_t e;
        ye  = s ? ~y : y;
        sum = {1'b0, x} + {1'b0, ye} + {32'd0, s};
        e.r = sum[31:0];
        e.c = sum[32];
        e.o = (x[31] == ye[31]) && (sum[31] != x[31]);
        e.z = (sum[31:0] == 32'd0);
        e.t = t;
        return e;
    endfunction

    function automatic vec_t mk(logic [31:0] xa, logic [31:0] xb, logic xs, logic [4:0] xt,
                                logic [31:0] r, logic c, logic o, logic z);
        vec_t v;
        v.a = xa;
        v.b = xb;
        v.s = xs;
        v.t = xt;
        v.e = {r, c, o, z, xt};
        return v;
    endfunction

    function automatic exp_t got(int d);
        return {res[d], cy[d], of[d], zr[d], tg[d]};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    task automatic drain();
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && (sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0; i++) begin
            @(posedge clk);
            #1;
        end
        for (int d = 0; d < 3; d++) chk($sformatf("drain_empty_s%0d", ST[d]), 64'(sbq[d].size()), 64'd0);
    endtask

    task automatic lat_test(input logic [31:0] xa, input logic [31:0] xb, input logic xs, input logic [4:0] xt);
        @(posedge clk);
        #1;
        a = xa; b = xb; sub = xs; tag_in = xt; in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            @(negedge clk);
            for (int d = 0; d < 3; d++)
                chk($sformatf("latency_s%0d_k%0d", ST[d], k), 64'(ov[d]), 64'(k == ST[d]));
        end
    endtask

    task automatic send(input logic [31:0] xa, input logic [31:0] xb, input logic xs, input logic [4:0] xt);
        a = xa; b = xb; sub = xs; tag_in = xt; in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ir[0]) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        n_chk++;
        n_fail++;
        $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 50 cycles");
        in_valid = 1'b0;
    endtask

    // Scoreboard: push the model result on each accepted input, compare on every valid output, pop on handshake
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                sbq[d].delete();
                stall_prev[d] = 1'b0;
            end else begin
                if (stall_prev[d]) chk($sformatf("hold_valid_s%0d", ST[d]), 64'(ov[d]), 64'd1);
                if (ov[d]) begin
                    if (sbq[d].size() == 0) begin
                        chk($sformatf("spurious_out_s%0d", ST[d]), 64'(ov[d]), 64'd0);
                    end else begin
                        chk($sformatf("out_s%0d", ST[d]), 64'(got(d)), 64'(sbq[d][0]));
                        if (out_ready) begin
                            void'(sbq[d].pop_front());
                            n_out[d]++;
                        end
                    end
                end
                if (in_valid && ir[d]) sbq[d].push_back(model(a, b, sub, tag_in));
                stall_prev[d] = ov[d] && !out_ready;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        tbl[0] = mk(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 5'h01, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        tbl[1] = mk(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 5'h02, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        tbl[2] = mk(32'h0000_FFFF, 32'h0000_0001, 1'b0, 5'h03, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
        tbl[3] = mk(32'h0000_0005, 32'h0000_0007, 1'b1, 5'h13, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        tbl[4] = mk(32'h8000_0000, 32'h0000_0001, 1'b1, 5'h04, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        tbl[5] = mk(32'h0000_0007, 32'h0000_0007, 1'b1, 5'h05, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        tbl[6] = mk(32'h0000_0000, 32'h0000_0000, 1'b0, 5'h06, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
        tbl[7] = mk(32'h8000_0000, 32'h8000_0000, 1'b0, 5'h07, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
        tbl[8] = mk(32'h1234_5678, 32'h0000_FFFF, 1'b0, 5'h1F, 32'h1235_5677, 1'b0, 1'b0, 1'b0);
        for (int d = 0; d < 3; d++) begin
            n_out[d] = 0;
            stall_prev[d] = 1'b0;
        end
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; tag_in = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_state_s%0d", ST[d]), 64'({ov[d], res[d], cy[d], of[d], zr[d], tg[d]}), 64'd0);
            chk($sformatf("rst_ready_s%0d", ST[d]), 64'(ir[d]), 64'd1);
        end

        lat_test(32'h0000_1234, 32'h0000_0001, 1'b0, 5'h03);

        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
            a = tbl[i].a; b = tbl[i].b; sub = tbl[i].s; tag_in = tbl[i].t; in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d", i), 64'(got(0)), 64'(tbl[i].e));
            chk($sformatf("vec%0d_valid", i), 64'(ov[0]), 64'd1);
        end
        drain();

        a = 32'h0000_0011; b = 32'h0000_0022; sub = 1'b0; tag_in = 5'h0A; in_valid = 1'b1;
        @(posedge clk);
        #1;
        a = 32'h0000_0033; b = 32'h0000_0044; tag_in = 5'h0B;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) chk($sformatf("post_rst_valid_s%0d_c%0d", ST[d], c), 64'(ov[d]), 64'd0);
            if (c == 0) chk("post_rst_ready", 64'(ir[0]), 64'd1);
        end
        lat_test(32'h0000_0100, 32'h0000_0001, 1'b1, 5'h0C);

        @(posedge clk);
        #1;
        base = n_out[0];
        fork
            begin
                for (int i = 0; i < 4; i++)
                    send(32'h1000_0000 * i + 32'h0000_FFFF, 32'h0000_0001 + i, i[0], 5'(i + 16));
            end
            begin
                @(posedge clk);
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_in_ready", 64'(ir[0]), 64'd0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        chk("stall_delivered", 64'(n_out[0] - base), 64'd4);

        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = pick();
            b         = pick();
            sub       = 1'($urandom_range(0, 1));
            tag_in    = 5'($urandom_range(0, 31));
            out_ready = ($urandom_range(0, 3) != 0);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; SHALL be a multiple of STAGES.
REQ-002 Parameter STAGES, default 2, pipeline depth, legal range 1..4.
REQ-003 Parameter TAG_W, default 5, width of the pass-through tag (destination register index).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  operand set presented.
REQ-007 in_ready  output  1  block accepts operands this cycle.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 sub  input  1  0 = A+B, 1 = A-B.
REQ-011 tag_in  input  TAG_W  opaque tag carried with the operation.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  consumer accepts result this cycle.
REQ-014 result  output  WIDTH  sum/difference, modulo 2^WIDTH.
REQ-015 carry  output  1  carry out of MSB (for sub: 1 = no borrow).
REQ-016 ovf  output  1  two's-complement signed overflow.
REQ-017 zero  output  1  result == 0.
REQ-018 tag_out  output  TAG_W  tag of the operation on result.

Function
REQ-019 Operation SHALL compute A + (sub ? ~B : B) + sub as one WIDTH-bit add with carry-in.
REQ-020 The add SHALL be split into STAGES slices of WIDTH/STAGES bits; stage k adds slice k using the registered carry from stage k-1; upper-slice operands and lower-slice results skewed by registers.
REQ-021 Latency SHALL be exactly STAGES cycles from accepted input (in_valid & in_ready) to out_valid, with no stalls.
REQ-022 Throughput SHALL be one operation per cycle while out_ready is held high.
REQ-023 Pipeline advance: adv = ~out_valid | out_ready; in_ready SHALL equal adv (combinational); all stages move together when adv = 1 and hold when adv = 0.
REQ-024 Each stage SHALL carry a valid bit; bubbles (in_valid = 0 while adv = 1) SHALL propagate as invalid stages.
REQ-025 While out_valid = 1 and out_ready = 0, result, carry, ovf, zero, tag_out SHALL remain stable.
REQ-026 ovf SHALL be 1 iff MSB(A) == MSB(effective B) and MSB(result) != MSB(A).
REQ-027 zero SHALL be derived from the final registered result, not partial slices.
REQ-028 No operation SHALL be lost or duplicated under any in_valid/out_ready pattern.
REQ-029 in_valid asserted while in_ready = 0 SHALL have no effect; source holds operands.

Reset
REQ-030 With rst = 1 at a rising edge, all stage valid bits SHALL clear; out_valid = 0; result, carry, ovf, zero, tag_out = 0.
REQ-031 Reset mid-operation SHALL discard all in-flight operations; no result from before reset SHALL appear after it.
REQ-032 in_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-033 Opcode constants (ADD = 0, SUB = 1) and default WIDTH/STAGES SHALL live in the shared processor package.
REQ-034 One sub-module add_slice (slice-width adder with carry-in/carry-out, combinational) SHALL be instantiated STAGES times via generate.
REQ-035 Parameter legality (WIDTH % STAGES == 0, STAGES 1..4) SHALL be checked at elaboration.

Verification (WIDTH=32, STAGES=2 unless stated)
REQ-036 A=0xFFFFFFFF, B=1, add -> after 2 cycles result=0x00000000, carry=1, ovf=0, zero=1.
REQ-037 A=0x7FFFFFFF, B=1, add -> result=0x80000000, carry=0, ovf=1; A=0x0000FFFF, B=1 -> 0x00010000 (carry across slice boundary).
REQ-038 A=5, B=7, sub, tag=0x13 -> result=0xFFFFFFFE, carry=0, ovf=0, zero=0, tag_out=0x13; A=0x80000000, B=1, sub -> 0x7FFFFFFF, ovf=1.
REQ-039 Four back-to-back ops, out_ready low for 3 cycles after first result -> in_ready low during stall, result held, all four results delivered in order, none duplicated.
REQ-040 Two ops in flight, rst pulsed one cycle -> out_valid stays 0 afterwards, no stale result; next op after reset completes with latency 2.
REQ-041 STAGES=1 and STAGES=4 builds with random operands and random out_ready -> results match reference model, latency equals STAGES.
